// File: rtl/nrisc_exec_unit.sv
// NRISC execution unit: register file, ALU, flags and a multi-cycle control FSM
// accepting 16-bit instructions over valid/ready and reporting each retirement.
module nrisc_exec_unit #(
  parameter int TAM    = 16,
  parameter int NREG   = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    instr_in,
  input  logic           instr_valid,
  output logic           instr_ready,
  output logic           res_valid,
  output logic [3:0]     res_rd,
  output logic [TAM-1:0] res_data,
  output logic [2:0]     flags,
  output logic           busy,
  output logic           halted,
  output logic           err,
  input  logic [3:0]     dbg_addr,
  output logic [TAM-1:0] dbg_data
);

  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(TAM);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_HALT} state_t;

  state_t             state_q;
  logic [TAM-1:0]     regs_q [NREG];
  logic [3:0]         op_q;
  logic [RW-1:0]      rd_q;
  logic [TAM-1:0]     a_q, b_q, imm_q;
  logic [2:0]         flags_q;
  logic               res_valid_q, err_q;
  logic [3:0]         res_rd_q;
  logic [TAM-1:0]     res_data_q;
  logic [2*TAM-1:0]   prod_q, mcand_q;
  logic [TAM-1:0]     mplier_q;
  logic [CW-1:0]      cnt_q;

  logic [TAM:0]       sum_s;
  logic [TAM-1:0]     res_s;
  logic               c_s, wr_s, fl_s, ill_s;
  logic [2*TAM-1:0]   prod_d;
  logic [RW-1:0]      rf1_s, rf2_s;

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q == S_EXEC) || (state_q == S_MUL);
  assign halted      = (state_q == S_HALT);
  assign res_valid   = res_valid_q;
  assign res_rd      = res_rd_q;
  assign res_data    = res_data_q;
  assign err         = err_q;
  assign flags       = flags_q;
  assign dbg_data    = regs_q[dbg_addr[RW-1:0]];
  assign rf1_s       = instr_in[4 +: RW];
  assign rf2_s       = instr_in[0 +: RW];
  assign prod_d      = prod_q + (mplier_q[0] ? mcand_q : {(2*TAM){1'b0}});

  // Single-cycle ALU result, carry and write/flag enables for the latched op
  always_comb begin
    sum_s = '0;
    res_s = '0;
    c_s   = 1'b0;
    wr_s  = 1'b0;
    fl_s  = 1'b0;
    ill_s = 1'b0;
    case (op_q)
      4'h0: begin sum_s = {1'b0, a_q} + {1'b0, b_q}; res_s = sum_s[TAM-1:0]; c_s = sum_s[TAM]; wr_s = 1'b1; fl_s = 1'b1; end
      4'h1: begin sum_s = {1'b0, a_q} - {1'b0, b_q}; res_s = sum_s[TAM-1:0]; c_s = sum_s[TAM]; wr_s = 1'b1; fl_s = 1'b1; end
      4'h2: begin res_s = a_q & b_q; wr_s = 1'b1; fl_s = 1'b1; end
      4'h3: begin res_s = a_q | b_q; wr_s = 1'b1; fl_s = 1'b1; end
      4'h4: begin res_s = a_q ^ b_q; wr_s = 1'b1; fl_s = 1'b1; end
      4'h5: begin res_s = {a_q[TAM-2:0], 1'b0}; c_s = a_q[TAM-1]; wr_s = 1'b1; fl_s = 1'b1; end
      4'h6: begin res_s = {1'b0, a_q[TAM-1:1]}; c_s = a_q[0]; wr_s = 1'b1; fl_s = 1'b1; end
      4'h7: begin res_s = ~a_q; wr_s = 1'b1; fl_s = 1'b1; end
      4'h8: begin sum_s = {1'b0, a_q} + (TAM+1)'(1); res_s = sum_s[TAM-1:0]; c_s = sum_s[TAM]; wr_s = 1'b1; fl_s = 1'b1; end
      4'h9: begin sum_s = {1'b0, a_q} - (TAM+1)'(1); res_s = sum_s[TAM-1:0]; c_s = sum_s[TAM]; wr_s = 1'b1; fl_s = 1'b1; end
      4'hA: begin res_s = imm_q; wr_s = 1'b1; end
      4'hB: begin res_s = a_q; wr_s = 1'b1; end
      4'hC: begin sum_s = {1'b0, a_q} - {1'b0, b_q}; res_s = sum_s[TAM-1:0]; c_s = sum_s[TAM]; fl_s = 1'b1; end
      // MUL only lands in EXEC when the multiplier is not built
      4'hD: ill_s = 1'b1;
      default: ;
    endcase
  end

  // Control FSM, register file, flags and registered retire outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      op_q        <= 4'h0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      flags_q     <= 3'b000;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_rd_q    <= 4'h0;
      res_data_q  <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q     <= instr_in[15:12];
            rd_q     <= instr_in[8 +: RW];
            a_q      <= regs_q[rf1_s];
            b_q      <= regs_q[rf2_s];
            imm_q    <= TAM'(instr_in[7:0]);
            prod_q   <= '0;
            mcand_q  <= {{TAM{1'b0}}, regs_q[rf1_s]};
            mplier_q <= regs_q[rf2_s];
            cnt_q    <= '0;
            if (instr_in[15:12] == 4'hF) begin
              state_q     <= S_HALT;
              res_valid_q <= 1'b1;
              res_rd_q    <= 4'(instr_in[8 +: RW]);
              res_data_q  <= '0;
            end else if (instr_in[15:12] == 4'hD && MUL_EN) begin
              state_q <= S_MUL;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (wr_s) regs_q[rd_q] <= res_s;
          if (fl_s) flags_q <= {res_s[TAM-1], res_s == '0, c_s};
          res_valid_q <= 1'b1;
          err_q       <= ill_s;
          res_rd_q    <= 4'(rd_q);
          res_data_q  <= res_s;
          state_q     <= S_IDLE;
        end
        S_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[2*TAM-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[TAM-1:1]};
          cnt_q    <= cnt_q + CW'(1);
          // The final partial product is folded in on the retiring edge
          if (cnt_q == CW'(TAM-1)) begin
            regs_q[rd_q] <= prod_d[TAM-1:0];
            flags_q      <= {prod_d[TAM-1], prod_d[TAM-1:0] == '0, prod_d[2*TAM-1:TAM] != '0};
            res_valid_q  <= 1'b1;
            res_rd_q     <= 4'(rd_q);
            res_data_q   <= prod_d[TAM-1:0];
            state_q      <= S_IDLE;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nrisc_exec_unit.md
Name: nrisc_exec_unit

Overview:
Parametrised successor of the NRISC processor top. It merges ALU, register file, flag register and a multi-cycle control FSM into one self-contained execution unit. It accepts 16-bit NRISC-style instructions over a valid/ready handshake, executes them, writes back results, and reports each retirement on a result port. Over the previous generation it adds a configurable data width and register count, an optional iterative multiplier, a HALT state and an illegal-op error pulse.

Parameters:
TAM, 16, datapath width in bits (>=8).
NREG, 16, number of registers; power of two, 2..16. Register fields use the low log2(NREG) bits.
MUL_EN, 1, 1 = MUL implemented as a shift-add unit; 0 = MUL is illegal.

Ports:
clk  input  1  main clock
rst  input  1  synchronous active-high reset
instr_in  input  16  instruction: [15:12] op, [11:8] rd, [7:4] rf1, [3:0] rf2
instr_valid  input  1  instruction present
instr_ready  output  1  unit can accept
res_valid  output  1  one-cycle retire pulse
res_rd  output  4  destination index of the retired instruction
res_data  output  TAM  value written (CMP: difference; NOP: 0)
flags  output  3  {M,Z,C}
busy  output  1  high in EXEC or MUL
halted  output  1  high in HALT
err  output  1  one-cycle illegal-op pulse
dbg_addr  input  4  debug register index
dbg_data  output  TAM  combinational read of reg[dbg_addr]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all registers 0; flags 000; state IDLE; res_valid, res_rd, res_data, err, halted all 0; instr_ready 0 while rst is high.
- FSM states: IDLE, EXEC, MUL, HALT. instr_ready = (state==IDLE) && !rst.
- IDLE: on instr_valid && instr_ready at edge E, latch the instruction and operands.
  - Go to MUL if op==D and MUL_EN=1.
  - Go to HALT if op==F.
  - Otherwise go to EXEC.
- EXEC: at edge E+1, write reg[rd] (if the op writes), update flags (if the op affects them), set res_valid=1 for one cycle, return to IDLE.
  - Throughput is one instruction per 2 cycles.
  - Next instruction sees the updated regfile, so there are no hazards.
- Opcodes:
  - 0 ADD: rd=a+b; C = carry out.
  - 1 SUB: rd=a-b; C = borrow (a<b unsigned).
  - 2 AND, 3 OR, 4 XOR, 7 NOT(a): C=0.
  - 5 SHL: rd=a<<1; C=a[TAM-1].
  - 6 SHR: rd=a>>1 (logical); C=a[0].
  - 8 INC: rd=a+1; C = carry.
  - 9 DEC: rd=a-1; C = borrow.
  - A LDI: rd = zero-extended instr[7:0]; flags unchanged.
  - B MOV: rd=a; flags unchanged.
  - C CMP: computes a-b; updates flags only, no write.
  - D MUL: see below.
  - E NOP: no write, flags unchanged, res_valid still pulses.
  - F HALT.
- Operand encoding: a = reg[rf1], b = reg[rf2]. M = result[TAM-1]; Z = (result==0).
- MUL (MUL_EN=1): unsigned shift-add, one bit per cycle, TAM cycles in MUL, counter from 0 to TAM-1.
  - Retire on the edge after the last iteration, i.e. res_valid in cycle E+TAM+1.
  - rd = low TAM bits; C = (high half != 0); M and Z computed from the low half.
- MUL with MUL_EN=0: handled in EXEC as illegal. err pulses together with res_valid; no write; flags unchanged.
- HALT: one res_valid pulse, then halted=1, instr_ready=0 until rst. instr_valid is ignored.
- Reset mid-operation: aborts MUL or EXEC with no write and no res_valid; the unit is in IDLE the cycle after rst is deasserted.
- Width rules: all arithmetic is modulo 2^TAM. Register indices are taken modulo NREG for rd, rf1, rf2 and dbg_addr.
- Write and debug read in the same cycle: dbg_data shows the old value until the edge, the new value after it.
- instr_valid while not ready: the instruction is not consumed. The source must hold it.

Test Plan:
- Reset then LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 -> res_data=0x0008, res_rd=3, flags=000, dbg_data(3)=0x0008, each res_valid 2 cycles after accept.
- TAM=16: LDI r1,0xFF; SHL ×8 to reach 0xFF00; then ADD of 0xFF00+0x0100 -> result 0x0000, flags=011 (Z,C). CMP 0x0003,0x0005 -> flags=101 (M,C), no register change.
- MUL_EN=1: r1=0x0012, r2=0x0034, MUL r4 -> res_valid exactly 17 cycles after accept, r4=0x03A8, C=0, busy high for 16 MUL cycles.
- MUL_EN=0: MUL instruction -> err=1 and res_valid=1 in the same cycle, registers and flags unchanged. NREG=4: LDI r5,0x7 writes r1.
- Assert rst at the 5th MUL cycle -> no res_valid, r4 unchanged (0 after reset), instr_ready=1 in the cycle after deassert.
- HALT then instr_valid held high with ADD -> one res_valid, halted=1, instr_ready=0 indefinitely; rst restores IDLE with regs=0.
